instr_mem_loadable: RTL
=======================

# instr_mem_loadable

Parametrised, loadable instruction memory for the lab CPU fetch stage; replaces the hard-coded combinational instruction table. Word width, address width and depth are parameters. After reset a program is streamed in over a valid/ready load port, then the core fetches over a request/valid port with one-cycle registered read latency. A reload request returns the block to the load phase without a reset.

## Interface
- ADDR_W, 8, fetch and load address width
- INSTR_W, 9, instruction word width
- DEPTH, 256, implemented words; must satisfy DEPTH ≤ 2^ADDR_W
- NOP_INSTR, 0, word returned for out-of-range fetches and while idle

Ports. Reset is asynchronous and active-low.
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  load word present
- load_ready  out  1  block accepts a load word
- load_data  in  INSTR_W  word to store at the internal load pointer
- load_last  in  1  qualifies the final word of the program
- reload  in  1  single-cycle pulse; re-enter the load phase
- loaded  out  1  program present, fetch enabled
- load_count  out  ADDR_W+1  words accepted in the current or last load
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  fetch address
- fetch_ready  out  1  equals loaded
- instr_valid  out  1  pulse: instruction is valid this cycle
- instruction  out  INSTR_W  fetched word
- addr_err  out  1  with instr_valid: the fetch address was ≥ DEPTH

## Operation
- Two states: LOAD and RUN. Reset enters LOAD.
- LOAD state:
  - load_ready = 1.
  - Each handshake (load_valid & load_ready) writes load_data to mem[ptr], increments ptr and load_count.
  - Transition to RUN when the accepted word has load_last = 1, or when ptr = DEPTH-1.
- RUN state:
  - load_ready = 0 and loaded = 1.
  - A fetch handshake (fetch_req & fetch_ready) performs a registered read.
  - A fetch_addr ≥ DEPTH returns NOP_INSTR with addr_err = 1.
- reload while in RUN:
  - Next state is LOAD; ptr and load_count are cleared; loaded drops the next cycle.
  - A fetch accepted in the same cycle as reload still completes.
  - reload while in LOAD is ignored.
- Memory contents are never reset. Words beyond load_count keep their old values and are returned unflagged.
- load_count saturates at DEPTH.

## Timing
- Reset values:
  - state = LOAD, ptr = 0, load_count = 0
  - loaded = 0, fetch_ready = 0, load_ready = 1
  - instr_valid = 0, addr_err = 0, instruction = NOP_INSTR
- Fetch latency is 1 cycle. A request accepted at edge N gives instr_valid/instruction/addr_err during cycle N+1. Back-to-back fetches sustain one per cycle.
- instruction holds its last value when instr_valid = 0.
- The load word with load_last accepted at edge N gives loaded = 1 from cycle N+1. The first fetch can be accepted at edge N+1; its data is the just-written word.
- Asserting rst_n low at any point, including mid-load or with a fetch in flight, forces the reset values immediately. A pending instr_valid is dropped.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word is stored with an even-parity bit computed at load time.
  - Extra output parity_err (1 bit), valid with instr_valid; it is 1 when the read parity mismatches.
  - parity_err is forced to 0 on addr_err fetches; its reset value is 0.
- IMEM_PARITY_EN undefined: no parity storage and no parity_err port.

## Structure
- Package imem_pkg holds:
  - state enum imem_state_t {IMEM_LOAD, IMEM_RUN}
  - the default NOP constant
  - the parity helper function
- Sub-module imem_ram: a DEPTH × (INSTR_W [+1]) single write port plus registered read port array. The top level holds the FSM, the pointer, and the out-of-range and parity logic.

## Test plan
- Reset, stream 4 words 0x140, 0x161, 0x0AA, 0x00A (last on the 4th) → load_count = 4; loaded rises the cycle after; fetches of 0..3 return the same words, one cycle later each.
- Back-to-back fetches at addrs 3, 0, 2 on consecutive cycles → instr_valid high 3 consecutive cycles with 0x00A, 0x140, 0x0AA.
- DEPTH = 16, fetch addr 20 → instruction = NOP_INSTR, addr_err = 1 for one cycle.
- Stream 16 words without load_last at DEPTH = 16 → auto-transition to RUN; load_count = 16; load_ready = 0.
- reload in the same cycle as a fetch of addr 1 → fetch returns 0x161; loaded = 0 next cycle; new program load overwrites address 0.
- rst_n low mid-load after 2 words → all outputs at reset values; with IMEM_PARITY_EN, corrupt a stored bit via the bench → parity_err = 1 on the read.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types, constants and helpers for the loadable instruction memory.
// Optional feature macro: IMEM_PARITY_EN (even-parity bit stored per word).
package imem_pkg;

  typedef enum logic {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_t;

  // Default word returned for idle / out-of-range fetches (truncated to INSTR_W).
  localparam logic [63:0] IMEM_NOP_DEFAULT = 64'h0;

  // Even-parity bit: XOR of all word bits, so word plus bit has an even count of ones.
  // Callers zero-extend the word to 64 bits; zero padding does not change the result.
  function automatic logic imem_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single write port, single registered read port word array.
// Contents are never reset; the read register only updates on a read enable.
module imem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Write port and registered read; read holds its value between reads.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: program streamed in during LOAD, then fetched
// with one-cycle latency during RUN. reload returns to LOAD without reset.
// Optional feature macro: IMEM_PARITY_EN adds stored parity and parity_err.
module instr_mem_loadable
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 9,
  parameter int DEPTH = 256,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IMEM_NOP_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  input  logic               reload,
  output logic               loaded,
  output logic [ADDR_W:0]    load_count,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic               addr_err
`ifdef IMEM_PARITY_EN
  ,
  output logic               parity_err
`endif
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int RAM_W = INSTR_W + 1;
`else
  localparam int RAM_W = INSTR_W;
`endif

  imem_state_t       state_q, state_d;
  logic [RAM_AW-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              instr_valid_q, instr_valid_d;
  logic              oor_q, oor_d;          // last accepted fetch was out of range
  logic              fetched_q, fetched_d;  // any fetch since reset (else show NOP)

  logic              load_hs, fetch_hs, in_range;
  logic [RAM_W-1:0]  ram_wdata, ram_rdata;

  assign load_hs  = load_valid && (state_q == IMEM_LOAD);
  assign fetch_hs = fetch_req && (state_q == IMEM_RUN);
  // Compare one bit wider so DEPTH == 2^ADDR_W does not wrap to zero.
  assign in_range = ({1'b0, fetch_addr} < (ADDR_W+1)'(DEPTH));

`ifdef IMEM_PARITY_EN
  assign ram_wdata = {imem_parity(64'(load_data)), load_data};
`else
  assign ram_wdata = load_data;
`endif

  // Load/run sequencing, load pointer and saturating word count.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      IMEM_LOAD: begin
        if (load_hs) begin
          ptr_d = ptr_q + RAM_AW'(1);
          if (count_q < (ADDR_W+1)'(DEPTH)) count_d = count_q + (ADDR_W+1)'(1);
          if (load_last || (ptr_q == RAM_AW'(DEPTH-1))) state_d = IMEM_RUN;
        end
      end
      IMEM_RUN: begin
        if (reload) begin
          state_d = IMEM_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = IMEM_LOAD;
    endcase
  end

  // Fetch response tracking; a fetch accepted alongside reload still completes.
  always_comb begin
    instr_valid_d = fetch_hs;
    oor_d         = fetch_hs ? !in_range : oor_q;
    fetched_d     = fetched_q || fetch_hs;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IMEM_LOAD;
      ptr_q         <= '0;
      count_q       <= '0;
      instr_valid_q <= 1'b0;
      oor_q         <= 1'b0;
      fetched_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      instr_valid_q <= instr_valid_d;
      oor_q         <= oor_d;
      fetched_q     <= fetched_d;
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW),
    .W     (RAM_W)
  ) u_ram (
    .clk   (clk),
    .we    (load_hs),
    .waddr (ptr_q),
    .wdata (ram_wdata),
    .re    (fetch_hs && in_range),
    .raddr (fetch_addr[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  assign load_ready  = (state_q == IMEM_LOAD);
  assign loaded      = (state_q == IMEM_RUN);
  assign fetch_ready = loaded;
  assign load_count  = count_q;
  assign instr_valid = instr_valid_q;
  assign addr_err    = instr_valid_q && oor_q;
  // RAM read register is not reset, so mask it until a real in-range read lands.
  assign instruction = (fetched_q && !oor_q) ? ram_rdata[INSTR_W-1:0] : NOP_INSTR;

`ifdef IMEM_PARITY_EN
  assign parity_err = fetched_q && !oor_q &&
                      (ram_rdata[INSTR_W] != imem_parity(64'(ram_rdata[INSTR_W-1:0])));
`endif

endmodule
